// File: rtl/layer_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : layer_sequencer_if
// Description : Handshake and blender bus of the per-pixel layer sequencer.
//               The slave side is the sequencer. The master side is the
//               environment: the upstream stack source, the 1-cycle blender
//               and the scan-out sink.
// Revision    : 1.0 - initial release
// ============================================================================
interface layer_sequencer_if #(
  parameter int LAYERS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [16*LAYERS-1:0]  in_layers;
  logic [15:0]           blend_composited;
  logic [15:0]           blend_to_add;
  logic [15:0]           blend_result;
  logic                  out_valid;
  logic                  out_ready;
  logic [15:0]           out_pixel;

  modport master (
    output in_valid, in_layers, blend_result, out_ready,
    input  in_ready, blend_composited, blend_to_add, out_valid, out_pixel
  );

  modport slave (
    input  in_valid, in_layers, blend_result, out_ready,
    output in_ready, blend_composited, blend_to_add, out_valid, out_pixel
  );
endinterface
`default_nettype wire

// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : layer_sequencer
// Description : Walks a stack of ARGB4444 layers, bottom layer first. It
//               feeds an external 1-cycle blender one layer at a time and
//               folds each result back into an accumulator seeded with
//               BG_COLOR. The final opaque pixel is presented on a
//               valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_sequencer #(
  parameter int          LAYERS   = 4,
  parameter logic [15:0] BG_COLOR = 16'hF000
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  layer_sequencer_if.slave  bus
);

  localparam logic [2:0] LAST_IDX = 3'(LAYERS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q;
  logic [16*LAYERS-1:0]  layers_q;
  logic [15:0]           acc_q;
  logic [2:0]            idx_q;
  logic [2:0]            idx_d;
  logic [15:0]           cur_layer;

  assign idx_d = idx_q + 3'd1;

  // Select the layer addressed by idx_q; idx_q never exceeds LAYERS-1.
  always_comb begin
    cur_layer = 16'h0000;
    for (int k = 0; k < LAYERS; k++) begin
      if (idx_q == 3'(k)) begin
        cur_layer = layers_q[16*k +: 16];
      end
    end
  end

  assign bus.in_ready         = (state_q == S_IDLE);
  assign bus.out_valid        = (state_q == S_DONE);
  assign bus.blend_composited = acc_q;
  assign bus.blend_to_add     = cur_layer;
  // Scan-out pixels are always opaque; RGB comes straight from the blender.
  assign bus.out_pixel        = {4'hF, acc_q[11:0]};

  // Sequencer FSM: accept a stack, then issue/skip layers, then hand off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      layers_q <= '0;
      acc_q    <= 16'h0000;
      idx_q    <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            layers_q <= bus.in_layers;
            acc_q    <= BG_COLOR;
            idx_q    <= 3'd0;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // A zero-alpha layer leaves RGB unchanged, so it skips the blender.
          if (cur_layer[15:12] != 4'h0) begin
            state_q <= S_WAIT;
          end else if (idx_q == LAST_IDX) begin
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_d;
          end
        end
        S_WAIT: begin
          acc_q <= bus.blend_result;
          if (idx_q == LAST_IDX) begin
            state_q <= S_DONE;
          end else begin
            idx_q   <= idx_d;
            state_q <= S_ISSUE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
